// File: rtl/uart_tx_word_fifo.sv
// UART transmit path: DEPTH-entry word FIFO feeding a 1- or 4-byte 8N1 serialiser.
// Define TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
`timescale 1ns/1ps
module uart_tx_word_fifo #(
  parameter  int CLK_PER_HALF_BIT = 1042,
  parameter  int DEPTH            = 16,
  localparam int AW               = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   send_data,
  input  logic [1:0]    send_req,
  input  logic          flush,
  output logic          stall,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          overflow,
  output logic          txd
);

  localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
  localparam int BW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] BAUD_END = BW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t state, state_next;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_q, level_next;
  logic          full, push_req, push, pop;

  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_cnt;
  logic [31:0]   shift_word;
  logic [7:0]    cur_byte;
  logic          bit_end;
  logic          txd_next;

  assign full     = (level_q == LVL_FULL);
  assign push_req = send_req[1] && !flush;
  assign pop      = (state == S_IDLE) && (level_q != '0) && !flush;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);

  assign bit_end  = (baud_cnt == BAUD_END);
  assign cur_byte = shift_word[7:0];

  assign level = level_q;
  assign busy  = (state != S_IDLE);

  always_comb begin
    level_next = level_q;
    if (flush)
      level_next = '0;
    else if (push && !pop)
      level_next = level_q + LVL_ONE;
    else if (pop && !push)
      level_next = level_q - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {send_req[0], send_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      level_q <= level_next;
      stall   <= (level_next == LVL_FULL);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push_req && full && !pop)
          overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    txd_next   = 1'b1;
    case (state)
      S_IDLE: begin
        if (pop)
          state_next = S_START;
      end
      S_START: begin
        txd_next = 1'b0;
        if (bit_end)
          state_next = S_DATA;
      end
      S_DATA: begin
        txd_next = cur_byte[bit_idx];
        if (bit_end && (bit_idx == 3'd7))
`ifdef TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        txd_next = ^cur_byte;
        if (bit_end)
          state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end)
          state_next = (byte_cnt != 2'd0) ? S_START : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Flush abandons any partial frame and returns the line to idle immediately.
    if (flush) begin
      state_next = S_IDLE;
      txd_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      txd   <= 1'b1;
    end else begin
      state <= state_next;
      txd   <= txd_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_cnt   <= '0;
      shift_word <= '0;
    end else if (flush) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
    end else begin
      if ((state == S_IDLE) || bit_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + BW'(1);

      if (state != S_DATA)
        bit_idx <= '0;
      else if (bit_end)
        bit_idx <= bit_idx + 3'd1;

      if (pop) begin
        shift_word <= mem[rd_ptr][31:0];
        byte_cnt   <= mem[rd_ptr][32] ? 2'd3 : 2'd0;
      end else if ((state == S_STOP) && bit_end && (byte_cnt != 2'd0)) begin
        shift_word <= {8'h00, shift_word[31:8]};
        byte_cnt   <= byte_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Directed bench for uart_tx_word_fifo with a short bit period and a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_tx_word_fifo;

  localparam int CPHB  = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int BITC  = 2 * CPHB;
`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [31:0]   send_data = '0;
  logic [1:0]    send_req = '0;
  logic          flush = 1'b0;
  logic          stall, busy, overflow, txd;
  logic [AW:0]   level;

  int errors = 0;
  int checks = 0;
  int busy_cycles = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (busy === 1'b1) busy_cycles <= busy_cycles + 1;

  uart_tx_word_fifo #(.CLK_PER_HALF_BIT(CPHB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .send_data(send_data), .send_req(send_req),
    .flush(flush), .stall(stall), .level(level), .busy(busy),
    .overflow(overflow), .txd(txd)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] req, input logic [31:0] data, input logic fl);
    send_req  = req;
    send_data = data;
    flush     = fl;
    step(1);
    send_req  = '0;
    flush     = 1'b0;
  endtask

  // Call at cycle 3 of the start bit; returns at cycle 3 of the stop bit.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic exp_bit;
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i == 0)                   exp_bit = 1'b0;
      else if (i <= 8)              exp_bit = b[i-1];
      else if (i == FRAME_BITS - 1) exp_bit = 1'b1;
      else                          exp_bit = ^b;
      check_output($sformatf("%s bit%0d", tag, i), {31'b0, txd}, {31'b0, exp_bit});
      if (i < FRAME_BITS - 1)
        step(BITC);
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (txd !== 1'b0 && n < 200) begin
      step(1);
      n++;
    end
    check_output({tag, " start seen"}, {31'b0, txd}, 32'd0);
    step(3);
  endtask

  initial begin
    int b0;
    logic seen_low;
    logic [7:0] bytes3 [5];
    bytes3[0] = 8'hA1; bytes3[1] = 8'hB2; bytes3[2] = 8'hC3;
    bytes3[3] = 8'hD4; bytes3[4] = 8'hE5;

    step(2);
    check_output("rst txd", {31'b0, txd}, 32'd1);
    check_output("rst stall", {31'b0, stall}, 32'd0);
    check_output("rst level", {29'b0, level}, 32'd0);
    check_output("rst busy", {31'b0, busy}, 32'd0);
    check_output("rst overflow", {31'b0, overflow}, 32'd0);
    rstn = 1'b1;
    step(2);

    $display("[TB] single byte 0x99");
    b0 = busy_cycles;
    apply_stimulus(2'b10, 32'h0000_0099, 1'b0);
    check_output("t1 level after push", {29'b0, level}, 32'd1);
    check_output("t1 busy after push", {31'b0, busy}, 32'd0);
    step(1);
    check_output("t1 level after pop", {29'b0, level}, 32'd0);
    check_output("t1 busy after pop", {31'b0, busy}, 32'd1);
    check_output("t1 txd before start", {31'b0, txd}, 32'd1);
    step(1);
    check_output("t1 txd start edge", {31'b0, txd}, 32'd0);
    step(3);
    check_frame(8'h99, "t1");
    step(5);
    check_output("t1 busy end", {31'b0, busy}, 32'd0);
    check_output("t1 busy cycles", busy_cycles - b0, FRAME_BITS * BITC);

    $display("[TB] four bytes 0x11223344");
    step(3);
    b0 = busy_cycles;
    apply_stimulus(2'b11, 32'h1122_3344, 1'b0);
    step(1);
    step(1);
    check_output("t2 txd start edge", {31'b0, txd}, 32'd0);
    step(3);
    check_frame(8'h44, "t2 b0");
    step(BITC);
    check_frame(8'h33, "t2 b1");
    step(BITC);
    check_frame(8'h22, "t2 b2");
    step(BITC);
    check_frame(8'h11, "t2 b3");
    step(5);
    check_output("t2 busy end", {31'b0, busy}, 32'd0);
    check_output("t2 busy cycles", busy_cycles - b0, 4 * FRAME_BITS * BITC);

    $display("[TB] overflow with six pushes");
    step(3);
    apply_stimulus(2'b10, 32'h0000_00A1, 1'b0);
    check_output("t3 level p1", {29'b0, level}, 32'd1);
    apply_stimulus(2'b10, 32'h0000_00B2, 1'b0);
    check_output("t3 level p2", {29'b0, level}, 32'd1);
    apply_stimulus(2'b10, 32'h0000_00C3, 1'b0);
    check_output("t3 level p3", {29'b0, level}, 32'd2);
    apply_stimulus(2'b10, 32'h0000_00D4, 1'b0);
    check_output("t3 level p4", {29'b0, level}, 32'd3);
    check_output("t3 stall p4", {31'b0, stall}, 32'd0);
    apply_stimulus(2'b10, 32'h0000_00E5, 1'b0);
    check_output("t3 level p5", {29'b0, level}, 32'd4);
    check_output("t3 stall p5", {31'b0, stall}, 32'd1);
    check_output("t3 overflow p5", {31'b0, overflow}, 32'd0);
    apply_stimulus(2'b10, 32'h0000_00F6, 1'b0);
    check_output("t3 level p6", {29'b0, level}, 32'd4);
    check_output("t3 overflow p6", {31'b0, overflow}, 32'd1);
    check_frame(bytes3[0], "t3 e0");
    for (int k = 1; k < 5; k++) begin
      wait_start($sformatf("t3 e%0d", k));
      check_output($sformatf("t3 level e%0d", k), {29'b0, level}, 32'(4 - k));
      check_output($sformatf("t3 stall e%0d", k), {31'b0, stall}, 32'd0);
      check_frame(bytes3[k], $sformatf("t3 e%0d", k));
    end
    seen_low = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    check_output("t3 no sixth frame", {31'b0, seen_low}, 32'd0);
    check_output("t3 level drained", {29'b0, level}, 32'd0);
    check_output("t3 overflow sticky", {31'b0, overflow}, 32'd1);

    $display("[TB] flush mid-frame");
    apply_stimulus(2'b11, 32'h55AA_0F3C, 1'b0);
    apply_stimulus(2'b10, 32'h0000_0012, 1'b0);
    apply_stimulus(2'b10, 32'h0000_0034, 1'b0);
    check_output("t4 level queued", {29'b0, level}, 32'd2);
    check_output("t4 txd start edge", {31'b0, txd}, 32'd0);
    step(3);
    check_frame(8'h3C, "t4 b0");
    step(BITC);
    step(5 * BITC);
    check_output("t4 txd data bit4", {31'b0, txd}, 32'd0);
    check_output("t4 busy before flush", {31'b0, busy}, 32'd1);
    apply_stimulus(2'b00, 32'h0, 1'b1);
    check_output("t4 txd after flush", {31'b0, txd}, 32'd1);
    check_output("t4 busy after flush", {31'b0, busy}, 32'd0);
    check_output("t4 level after flush", {29'b0, level}, 32'd0);
    check_output("t4 overflow after flush", {31'b0, overflow}, 32'd0);
    check_output("t4 stall after flush", {31'b0, stall}, 32'd0);
    seen_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (txd !== 1'b1 || busy !== 1'b0) seen_low = 1'b1;
    end
    check_output("t4 quiet after flush", {31'b0, seen_low}, 32'd0);

    $display("[TB] push with flush");
    apply_stimulus(2'b11, 32'hDEAD_BEEF, 1'b1);
    check_output("t5 level", {29'b0, level}, 32'd0);
    check_output("t5 overflow", {31'b0, overflow}, 32'd0);
    check_output("t5 txd", {31'b0, txd}, 32'd1);
    step(5);
    check_output("t5 txd later", {31'b0, txd}, 32'd1);
    check_output("t5 busy later", {31'b0, busy}, 32'd0);

    $display("[TB] reset mid-frame");
    apply_stimulus(2'b10, 32'h0000_0000, 1'b0);
    step(2);
    check_output("t6 txd start", {31'b0, txd}, 32'd0);
    step(10);
    #2 rstn = 1'b0;
    #1;
    check_output("t6 txd async", {31'b0, txd}, 32'd1);
    check_output("t6 busy async", {31'b0, busy}, 32'd0);
    check_output("t6 level async", {29'b0, level}, 32'd0);
    step(2);
    rstn = 1'b1;
    step(20);
    check_output("t6 txd idle", {31'b0, txd}, 32'd1);
    check_output("t6 busy idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
